dm_sba_wb_bridge: RTL and testbench



---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_sba_wb_bridge.sv | 125 ++++++++++++
 tb/tb_dm_sba_wb_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared debug-module types: SBA engine state and the SBA-to-Wishbone bridge state.
package dm_pkg;

  typedef enum logic [2:0] {
    SbaIdle,
    SbaRead,
    SbaWrite,
    SbaWaitRead,
    SbaWaitWrite
  } sba_state_e;

  typedef enum logic [1:0] {
    WbIdle,
    WbBus,
    WbResp
  } sba_wb_state_e;

endpackage

// File: rtl/dm_sba_wb_bridge.sv
// Single-outstanding bridge from the debug module SBA req/gnt/r_valid port to a
// Wishbone classic master, with a bus timeout so a dead slave cannot hang the debugger.
module dm_sba_wb_bridge
  import dm_pkg::*;
#(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic                  sba_req_i,
  input  logic [BusWidth-1:0]   sba_add_i,
  input  logic                  sba_we_i,
  input  logic [BusWidth-1:0]   sba_wdata_i,
  input  logic [BusWidth/8-1:0] sba_be_i,
  output logic                  sba_gnt_o,
  output logic                  sba_r_valid_o,
  output logic [BusWidth-1:0]   sba_r_rdata_o,
  output logic                  sba_err_o,
  output logic [BusWidth-1:0]   wb_adr_o,
  output logic [BusWidth-1:0]   wb_dat_o,
  output logic [BusWidth/8-1:0] wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic [BusWidth-1:0]   wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam int BeW  = BusWidth / 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

  sba_wb_state_e     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BusWidth-1:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  logic [BeW-1:0]    sel_q, sel_d;
  logic              we_q, we_d, err_q, err_d;
  logic              gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt     = 1'b0;
    case (state_q)
      WbIdle: begin
        cnt_d = '0;
        if (sba_req_i && dmactive_i && !rst_i) begin
          gnt     = 1'b1;
          adr_d   = sba_add_i;
          dat_d   = sba_wdata_i;
          sel_d   = sba_be_i;
          we_d    = sba_we_i;
          state_d = WbBus;
        end
      end
      WbBus: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        // Error wins over a simultaneous ack; timeout only when the slave is silent.
        if (wb_err_i) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = WbResp;
        end else if (wb_ack_i) begin
          rdata_d = we_q ? '0 : wb_dat_i;
          err_d   = 1'b0;
          state_d = WbResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = WbResp;
        end
      end
      WbResp:  state_d = WbIdle;
      default: state_d = WbIdle;
    endcase
    if (!dmactive_i) begin
      state_d = WbIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WbIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign sba_gnt_o     = gnt;
  // A completion being cleared by dmactive is treated as aborted and not reported.
  assign sba_r_valid_o = (state_q == WbResp) && dmactive_i;
  assign sba_r_rdata_o = rdata_q;
  assign sba_err_o     = err_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = (state_q == WbBus);
  assign wb_stb_o      = (state_q == WbBus);

endmodule

// File: tb/tb_dm_sba_wb_bridge.sv
// Bench for dm_sba_wb_bridge: directed test-plan scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_dm_sba_wb_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, dmactive_i = 1'b1, sba_req_i = 1'b0, sba_we_i = 1'b0;
  logic [31:0] sba_add_i = '0, sba_wdata_i = '0, wb_dat_i = '0;
  logic [3:0]  sba_be_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic        sba_gnt_o, sba_r_valid_o, sba_err_o, wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] sba_r_rdata_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  dm_sba_wb_bridge #(.BusWidth(32), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .sba_req_i(sba_req_i), .sba_add_i(sba_add_i), .sba_we_i(sba_we_i),
    .sba_wdata_i(sba_wdata_i), .sba_be_i(sba_be_i),
    .sba_gnt_o(sba_gnt_o), .sba_r_valid_o(sba_r_valid_o),
    .sba_r_rdata_o(sba_r_rdata_o), .sba_err_o(sba_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: a bus transfer is "in flight" for a number of
  // cycles, then a completion is "pending" for exactly one cycle.
  bit          mdl_ok = 1'b0;
  bit          in_flight = 1'b0, completion = 1'b0;
  int          bus_cycle = 0;
  logic [31:0] m_adr = '0, m_dat = '0, m_rdata = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0, m_err = 1'b0;
  int          n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_gnt();
    return !rst_i && dmactive_i && sba_req_i && !in_flight && !completion;
  endfunction

  task automatic compare_outputs();
    bit ev;
    ev = completion && dmactive_i;
    chk("gnt", 32'(sba_gnt_o), 32'(exp_gnt()));
    chk("stb", 32'(wb_stb_o), 32'(in_flight));
    chk("cyc", 32'(wb_cyc_o), 32'(in_flight));
    chk("r_valid", 32'(sba_r_valid_o), 32'(ev));
    chk("wb_adr", wb_adr_o, m_adr);
    chk("wb_dat", wb_dat_o, m_dat);
    chk("wb_sel", 32'(wb_sel_o), 32'(m_sel));
    chk("wb_we", 32'(wb_we_o), 32'(m_we));
    if (ev) begin
      chk("rdata", sba_r_rdata_o, m_rdata);
      chk("err", 32'(sba_err_o), 32'(m_err));
    end
  endtask

  task automatic model_edge();
    bit g;
    g = exp_gnt();
    if (rst_i) begin
      mdl_ok = 1'b1; in_flight = 0; completion = 0; bus_cycle = 0;
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = 0; m_rdata = '0; m_err = 0;
    end else if (!dmactive_i) begin
      in_flight = 0; completion = 0;
    end else if (completion) begin
      completion = 0;
    end else if (in_flight) begin
      if (wb_err_i || wb_ack_i || bus_cycle == T) begin
        m_err   = wb_err_i || !wb_ack_i;
        m_rdata = (m_err || m_we) ? 32'h0 : wb_dat_i;
        in_flight = 0; completion = 1;
        n_done++;
        $display("txn %0d we=%0d adr=%h rdata=%h err=%0d after %0d bus cycles",
                 n_done, m_we, m_adr, m_rdata, m_err, bus_cycle);
      end else begin
        bus_cycle++;
      end
    end else if (g) begin
      m_adr = sba_add_i; m_dat = sba_wdata_i; m_sel = sba_be_i; m_we = sba_we_i;
      in_flight = 1; bus_cycle = 1;
    end
  endtask

  // One clock cycle: compare on the falling edge, advance the model on the
  // rising edge, return 1 time unit later so the caller can drive new inputs.
  task automatic cycle();
    @(negedge clk);
    if (mdl_ok) compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    sba_req_i = 0; wb_ack_i = 0; wb_err_i = 0; rst_i = 0; dmactive_i = 1;
  endtask

  task automatic request(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] be);
    sba_req_i = 1; sba_we_i = we; sba_add_i = adr; sba_wdata_i = wd; sba_be_i = be;
  endtask

  initial begin
    rst_i = 1;
    sba_req_i = 1;
    cycle(); cycle();
    chk("reset_gnt", 32'(sba_gnt_o), 32'h0);
    rst_i = 0;
    sba_req_i = 0;
    chk("reset_stb", 32'(wb_stb_o), 32'h0);
    chk("reset_adr", wb_adr_o, 32'h0);
    chk("reset_valid", 32'(sba_r_valid_o), 32'h0);
    cycle();

    // Read, ack in cycle 3.
    request(0, 32'h2000_0004, 32'h0, 4'hF);
    cycle();
    idle_inputs();
    chk("rd_stb_c1", 32'(wb_stb_o), 32'h1);
    cycle(); cycle();
    wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    chk("rd_valid_c4", 32'(sba_r_valid_o), 32'h1);
    chk("rd_rdata", sba_r_rdata_o, 32'hDEADBEEF);
    chk("rd_err", 32'(sba_err_o), 32'h0);
    chk("rd_stb_c4", 32'(wb_stb_o), 32'h0);
    cycle();

    // Write, zero-wait ack.
    request(1, 32'h0000_0010, 32'h1234_5678, 4'h3);
    cycle();
    idle_inputs();
    chk("wr_we", 32'(wb_we_o), 32'h1);
    chk("wr_sel", 32'(wb_sel_o), 32'h3);
    wb_ack_i = 1;
    cycle();
    idle_inputs();
    chk("wr_valid_c2", 32'(sba_r_valid_o), 32'h1);
    chk("wr_rdata", sba_r_rdata_o, 32'h0);
    cycle();

    // Slave error in cycle 2, then ack+err together.
    for (int rep = 0; rep < 2; rep++) begin
      request(0, 32'h0000_0100, 32'h0, 4'hF);
      cycle();
      idle_inputs();
      cycle();
      wb_err_i = 1; wb_ack_i = (rep == 1); wb_dat_i = 32'hCAFE_F00D;
      cycle();
      idle_inputs();
      chk("err_valid_c3", 32'(sba_r_valid_o), 32'h1);
      chk("err_flag", 32'(sba_err_o), 32'h1);
      chk("err_rdata", sba_r_rdata_o, 32'h0);
      cycle();
    end

    // Timeout.
    request(0, 32'h0000_0200, 32'h0, 4'hF);
    cycle();
    idle_inputs();
    for (int i = 1; i <= T; i++) begin
      chk("to_stb_high", 32'(wb_stb_o), 32'h1);
      cycle();
    end
    chk("to_valid", 32'(sba_r_valid_o), 32'h1);
    chk("to_err", 32'(sba_err_o), 32'h1);
    chk("to_stb_low", 32'(wb_stb_o), 32'h0);
    cycle();

    // Abort in cycle 2, late ack in 4, new request in 5.
    request(0, 32'h0000_0300, 32'h0, 4'hF);
    cycle();
    idle_inputs();
    cycle();
    dmactive_i = 0;
    cycle();
    idle_inputs();
    chk("ab_cyc_low", 32'(wb_cyc_o), 32'h0);
    cycle();
    wb_ack_i = 1;
    cycle();
    idle_inputs();
    chk("ab_no_valid", 32'(sba_r_valid_o), 32'h0);
    request(0, 32'h0000_0400, 32'h0, 4'hF);
    #1;
    chk("ab_regrant", 32'(sba_gnt_o), 32'h1);
    cycle();
    idle_inputs();
    wb_ack_i = 1;
    cycle();
    idle_inputs();
    cycle();

    // Reset mid-bus.
    request(1, 32'h0000_0500, 32'h5555_AAAA, 4'hC);
    cycle();
    idle_inputs();
    cycle();
    rst_i = 1;
    cycle();
    idle_inputs();
    chk("rst_stb", 32'(wb_stb_o), 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_we", 32'(wb_we_o), 32'h0);
    chk("rst_valid", 32'(sba_r_valid_o), 32'h0);
    cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      sba_req_i   = ($urandom_range(0, 1) == 1);
      sba_we_i    = $urandom_range(0, 1) == 1;
      sba_add_i   = $urandom;
      sba_wdata_i = $urandom;
      sba_be_i    = 4'($urandom_range(0, 15));
      wb_dat_i    = $urandom;
      wb_ack_i    = ($urandom_range(0, 9) < 3);
      wb_err_i    = ($urandom_range(0, 19) == 0);
      dmactive_i  = ($urandom_range(0, 29) != 0);
      rst_i       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
